// File: rtl/board_controller_pkg.sv
// Shared chess definitions: piece codes, colours, square width and the start position.
// Also shared by the VGA board renderer.
package board_controller_pkg;

  localparam int unsigned SQ_W    = 6;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_SQ  = 64;
  localparam int unsigned BOARD_W = NUM_SQ * NIB_W;
  localparam int unsigned NUM_BTN = 5;

  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // Square 0 is the least significant nibble; rows listed 7 down to 0.
  localparam logic [BOARD_W-1:0] INIT_BOARD = {
    32'h4236_5324,   // row 7: white back rank
    32'h1111_1111,   // row 6: white pawns
    128'h0,          // rows 5..2: empty
    32'h9999_9999,   // row 1: black pawns
    32'hCABE_DBAC    // row 0: black back rank
  };

  typedef enum logic [1:0] {
    S_PICK   = 2'd0,
    S_PLACE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       color;
    logic [2:0] piece;
  } square_t;

  typedef struct packed {
    logic center;
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  function automatic logic [7:0] nib_base(input logic [SQ_W-1:0] sq);
    return {sq, 2'b00};
  endfunction

endpackage

// File: rtl/board_controller_if.sv
// Button inputs and renderer-facing outputs of the board controller.
interface board_controller_if;
  import board_controller_pkg::*;

  logic                 BTN_UP;
  logic                 BTN_DOWN;
  logic                 BTN_LEFT;
  logic                 BTN_RIGHT;
  logic                 BTN_CENTER;
  logic [BOARD_W-1:0]   BOARD;
  logic [SQ_W-1:0]      CURSOR_ADDR;
  logic [SQ_W-1:0]      SELECT_ADDR;
  logic                 SELECT_EN;
  logic                 TURN;
  logic                 MOVE_DONE;

  modport master (
    output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER,
    input  BOARD, CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE
  );

  modport slave (
    input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER,
    output BOARD, CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE
  );

endinterface

// File: rtl/board_controller_btn_edge.sv
// Button synchronizer followed by a registered one-cycle rising-edge pulse.
module btn_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/board_controller.sv
// Game-state stage: buttons -> cursor/selection FSM -> 64-square board register.
// Optional pawn promotion on commit: define BOARD_CONTROLLER_PROMOTION_EN.
module board_controller
  import board_controller_pkg::*;
#(
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [SQ_W-1:0] CURSOR_INIT = 6'd52
) (
  input  logic             CLK,
  input  logic             RESET,
  board_controller_if.slave bus
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] pulse_w;
  btn_t               btn_pulse;

  logic [BOARD_W-1:0] board_q;
  logic [SQ_W-1:0]    cursor_q;
  logic [SQ_W-1:0]    sel_addr_q;
  logic               sel_en_q;
  logic               turn_q;
  logic               move_done_q;
  state_t             state_q;

  square_t            cur_sq_c;
  square_t            src_sq_c;
  square_t            move_sq_c;
  logic [2:0]         row_c;
  logic [2:0]         col_c;
  logic               own_piece_c;

  assign btn_raw   = {bus.BTN_CENTER, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT};
  assign btn_pulse = btn_t'(pulse_w);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_edge (
      .CLK   (CLK),
      .RESET (RESET),
      .btn   (btn_raw[i]),
      .pulse (pulse_w[i])
    );
  end

  assign row_c = cursor_q[5:3];
  assign col_c = cursor_q[2:0];

  // Square under the cursor and the selected source square.
  always_comb begin
    cur_sq_c    = square_t'(board_q[nib_base(cursor_q) +: NIB_W]);
    src_sq_c    = square_t'(board_q[nib_base(sel_addr_q) +: NIB_W]);
    own_piece_c = (cur_sq_c.piece != PIECE_NONE) && (cur_sq_c.color == turn_q);
  end

  // Piece written to the destination; a pawn reaching the far rank may become a queen.
  always_comb begin
    move_sq_c = src_sq_c;
`ifdef BOARD_CONTROLLER_PROMOTION_EN
    if ((src_sq_c.piece == PIECE_PAWN) &&
        (row_c == ((src_sq_c.color == COLOR_WHITE) ? 3'd0 : 3'd7))) begin
      move_sq_c.piece = PIECE_QUEEN;
    end
`endif
  end

  // Selection FSM, cursor and board register; one button action per cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      board_q     <= INIT_BOARD;
      cursor_q    <= CURSOR_INIT;
      sel_addr_q  <= '0;
      sel_en_q    <= 1'b0;
      turn_q      <= COLOR_WHITE;
      move_done_q <= 1'b0;
      state_q     <= S_PICK;
    end else begin
      move_done_q <= 1'b0;
      unique case (state_q)
        S_PICK, S_PLACE: begin
          if (btn_pulse.center) begin
            if (state_q == S_PICK) begin
              if (own_piece_c) begin
                sel_addr_q <= cursor_q;
                sel_en_q   <= 1'b1;
                state_q    <= S_PLACE;
              end
            end else if (cursor_q == sel_addr_q) begin
              sel_en_q <= 1'b0;
              state_q  <= S_PICK;
            end else if (own_piece_c) begin
              sel_addr_q <= cursor_q;
            end else begin
              state_q <= S_COMMIT;
            end
          end else if (btn_pulse.up) begin
            if (row_c != 3'd0) cursor_q <= {row_c - 3'd1, col_c};
          end else if (btn_pulse.down) begin
            if (row_c != 3'd7) cursor_q <= {row_c + 3'd1, col_c};
          end else if (btn_pulse.left) begin
            if (col_c != 3'd0) cursor_q <= {row_c, col_c - 3'd1};
          end else if (btn_pulse.right) begin
            if (col_c != 3'd7) cursor_q <= {row_c, col_c + 3'd1};
          end
        end
        S_COMMIT: begin
          // Cursor is frozen here, so it still addresses the destination.
          board_q[nib_base(cursor_q) +: NIB_W]   <= move_sq_c;
          board_q[nib_base(sel_addr_q) +: NIB_W] <= '0;
          sel_en_q    <= 1'b0;
          turn_q      <= ~turn_q;
          move_done_q <= 1'b1;
          state_q     <= S_PICK;
        end
        default: state_q <= S_PICK;
      endcase
    end
  end

  assign bus.BOARD       = board_q;
  assign bus.CURSOR_ADDR = cursor_q;
  assign bus.SELECT_ADDR = sel_addr_q;
  assign bus.SELECT_EN   = sel_en_q;
  assign bus.TURN        = turn_q;
  assign bus.MOVE_DONE   = move_done_q;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: directed vector table, corner sequences, random presses vs. a model.
module tb_board_controller;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned GAP  = SYNC + 4;

  // Button mask bit order: {CENTER, UP, DOWN, LEFT, RIGHT}
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  board_controller_if bus ();

  board_controller #(.SYNC_STAGES(SYNC), .CURSOR_INIT(6'd52)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int move_cnt = 0;

  // Reference model: board as an array of piece nibbles, cursor as row/col.
  int m_board[64];
  int m_row, m_col, m_sa, m_moves;
  bit m_sel, m_turn;

  always @(negedge CLK) if (bus.MOVE_DONE === 1'b1) move_cnt++;

  typedef struct {
    logic [4:0] btn;
    logic [5:0] cur;
    logic       sel;
    logic [5:0] sa;
    logic       turn;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    for (int c = 0; c < 8; c++) begin
      m_board[c]      = 8 + back[c];
      m_board[8 + c]  = 9;
      m_board[48 + c] = 1;
      m_board[56 + c] = back[c];
    end
    m_row = 6; m_col = 4; m_sa = 0; m_sel = 0; m_turn = 0;
  endtask

  function automatic logic [255:0] model_board();
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 64; i++) b[4*i +: 4] = 4'(m_board[i]);
    return b;
  endfunction

  task automatic model_apply(input logic [4:0] m);
    int cur, p, mv;
    bit own;
    cur = m_row * 8 + m_col;
    p   = m_board[cur];
    own = (p % 8 != 0) && ((p / 8) == int'(m_turn));
    if (m[4]) begin
      if (!m_sel) begin
        if (own) begin m_sel = 1; m_sa = cur; end
      end else if (cur == m_sa) begin
        m_sel = 0;
      end else if (own) begin
        m_sa = cur;
      end else begin
        mv = m_board[m_sa];
`ifdef BOARD_CONTROLLER_PROMOTION_EN
        if ((mv % 8 == 1) && (m_row == ((mv / 8 == 1) ? 7 : 0))) mv = (mv / 8) * 8 + 5;
`endif
        m_board[cur]  = mv;
        m_board[m_sa] = 0;
        m_sel  = 0;
        m_turn = !m_turn;
        m_moves++;
      end
    end
    else if (m[3]) begin if (m_row > 0) m_row--; end
    else if (m[2]) begin if (m_row < 7) m_row++; end
    else if (m[1]) begin if (m_col > 0) m_col--; end
    else if (m[0]) begin if (m_col < 7) m_col++; end
  endtask

  task automatic set_btns(input logic [4:0] m);
    bus.BTN_CENTER = m[4];
    bus.BTN_UP     = m[3];
    bus.BTN_DOWN   = m[2];
    bus.BTN_LEFT   = m[1];
    bus.BTN_RIGHT  = m[0];
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge CLK);
    set_btns(m);
    repeat (HOLD) @(negedge CLK);
    set_btns(5'b0);
    repeat (GAP) @(negedge CLK);
    model_apply(m);
  endtask

  task automatic check_all(input string tag);
    check({tag, " cursor"}, 256'(bus.CURSOR_ADDR), 256'(m_row * 8 + m_col));
    check({tag, " sel_en"}, 256'(bus.SELECT_EN), 256'(m_sel));
    check({tag, " sel_addr"}, 256'(bus.SELECT_ADDR), 256'(m_sa));
    check({tag, " turn"}, 256'(bus.TURN), 256'(m_turn));
    check({tag, " moves"}, 256'(move_cnt), 256'(m_moves));
    check({tag, " board"}, bus.BOARD, model_board());
  endtask

  task automatic do_reset();
    @(negedge CLK);
    set_btns(5'b0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    m_moves = 0;
    set_btns(5'b0);
    model_reset();

    // Directed path: saturation, ownership, select/cancel, move, priority.
    tbl.push_back('{B_U, 6'd44, 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd36, 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd28, 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd20, 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd12, 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd4,  1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd4,  1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd4,  1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_U, 6'd4,  1'b0, 6'd0, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{B_L, 6'(3 - (i > 3 ? 3 : i)), 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_C, 6'd0,  1'b0, 6'd0, 1'b0});
    for (int i = 1; i <= 4; i++) tbl.push_back('{B_R, 6'(i), 1'b0, 6'd0, 1'b0});
    for (int i = 1; i <= 6; i++) tbl.push_back('{B_D, 6'(4 + 8 * i), 1'b0, 6'd0, 1'b0});
    tbl.push_back('{B_C, 6'd52, 1'b1, 6'd52, 1'b0});
    tbl.push_back('{B_C, 6'd52, 1'b0, 6'd52, 1'b0});
    tbl.push_back('{B_C, 6'd52, 1'b1, 6'd52, 1'b0});
    tbl.push_back('{B_U, 6'd44, 1'b1, 6'd52, 1'b0});
    tbl.push_back('{B_U, 6'd36, 1'b1, 6'd52, 1'b0});
    tbl.push_back('{B_C, 6'd36, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_U | B_L, 6'd28, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_C | B_U, 6'd28, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_D | B_R, 6'd36, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_C, 6'd36, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_U, 6'd28, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_U, 6'd20, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_U, 6'd12, 1'b0, 6'd52, 1'b1});
    tbl.push_back('{B_C, 6'd12, 1'b1, 6'd12, 1'b1});

    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset sq0", 256'(bus.BOARD[3:0]), 256'(4'b1100));
    check("reset sq52", 256'(bus.BOARD[211:208]), 256'(4'b0001));
    check("reset move_done", 256'(bus.MOVE_DONE), 256'(0));
    check_all("reset");

    foreach (tbl[i]) begin
      press(tbl[i].btn);
      check($sformatf("vec%0d cursor", i), 256'(bus.CURSOR_ADDR), 256'(tbl[i].cur));
      check($sformatf("vec%0d sel_en", i), 256'(bus.SELECT_EN), 256'(tbl[i].sel));
      if (tbl[i].sel) check($sformatf("vec%0d sel_addr", i), 256'(bus.SELECT_ADDR), 256'(tbl[i].sa));
      check($sformatf("vec%0d turn", i), 256'(bus.TURN), 256'(tbl[i].turn));
      check_all($sformatf("vec%0d", i));
    end
    check("move sq36", 256'(bus.BOARD[147:144]), 256'(4'b0001));
    check("move sq52", 256'(bus.BOARD[211:208]), 256'(4'b0000));
    check("move pulses", 256'(move_cnt), 256'(1));

    // Reset in the middle of a move restores everything asynchronously.
    do_reset();
    press(B_C);
    check("midreset selected", 256'(bus.SELECT_EN), 256'(1));
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    model_reset();
    check("midreset sel_en", 256'(bus.SELECT_EN), 256'(0));
    check("midreset cursor", 256'(bus.CURSOR_ADDR), 256'(52));
    check("midreset board", bus.BOARD, model_board());
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_all("after midreset");

    // Press-to-output latency is SYNC+2 cycles.
    set_btns(B_U);
    repeat (SYNC + 1) @(negedge CLK);
    check("latency early", 256'(bus.CURSOR_ADDR), 256'(52));
    @(negedge CLK);
    check("latency on time", 256'(bus.CURSOR_ADDR), 256'(44));
    set_btns(5'b0);
    repeat (GAP) @(negedge CLK);
    model_apply(B_U);
    check_all("latency");

    // A long hold yields a single step.
    set_btns(B_U);
    repeat (1000) @(negedge CLK);
    set_btns(5'b0);
    repeat (GAP) @(negedge CLK);
    model_apply(B_U);
    check("hold cursor", 256'(bus.CURSOR_ADDR), 256'(36));
    check_all("hold");

    // Random presses against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [4:0] m;
      r = int'($urandom_range(0, 11));
      if (r < 5)       m = 5'(1 << r);
      else if (r < 8)  m = B_C;
      else             m = 5'($urandom_range(1, 31));
      press(m);
      check_all($sformatf("rand%0d m=%b", n, m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
